// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Control sequencer for a multicycle MIPS datapath with a shared ALU, one
//   unified memory and an instruction register. Each instruction is stepped
//   through FETCH/DECODE/EXEC/MEM/WB states. All datapath mux selects and
//   enables are decoded from the current state. Memory states stall on
//   Mem_Ready so that slow memory is supported.
//   Supported instructions: lw, sw, R-type (add/sub/slt/mul), addi, beq, j.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   OpCode     in   IR[31:26]
//   Funct      in   IR[5:0]
//   Zero_flag  in   ALU zero result, used to qualify beq
//   Mem_Ready  in   memory access completes this cycle
//   IorD       out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register load
//   RegDst     out  destination register select (0 = rt, 1 = rd)
//   MemtoReg   out  write-back data select (0 = ALUOut, 1 = Data)
//   RegWrite   out  register file write enable
//   ALUSrcA    out  ALU A select (0 = PC, 1 = A)
//   ALUSrcB    out  ALU B select (B / 4 / SignImm / SignImm<<2)
//   ALUControl out  ALU operation
//   PCSrc      out  PC source (ALUResult / ALUOut / jump target)
//   PCEn       out  PC load enable
//   State      out  current state code, for debug
//
// Outputs are combinational from the current state. FETCH additionally uses
// Mem_Ready and BRANCH uses Zero_flag.
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int unsigned OpCode_WIDTH     = 6,
  parameter int unsigned Funct_Width      = 6,
  parameter int unsigned ALUControl_WIDTH = 3,
  parameter int unsigned STATE_WIDTH      = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [OpCode_WIDTH-1:0]       OpCode,
  input  logic [Funct_Width-1:0]        Funct,
  input  logic                          Zero_flag,
  input  logic                          Mem_Ready,
  output logic                          IorD,
  output logic                          MemWrite,
  output logic                          IRWrite,
  output logic                          RegDst,
  output logic                          MemtoReg,
  output logic                          RegWrite,
  output logic                          ALUSrcA,
  output logic [1:0]                    ALUSrcB,
  output logic [ALUControl_WIDTH-1:0]   ALUControl,
  output logic [1:0]                    PCSrc,
  output logic                          PCEn,
  output logic [STATE_WIDTH-1:0]        State
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH    = STATE_WIDTH'(0),
    S_DECODE   = STATE_WIDTH'(1),
    S_MEMADR   = STATE_WIDTH'(2),
    S_MEMRD    = STATE_WIDTH'(3),
    S_MEMWB    = STATE_WIDTH'(4),
    S_MEMWR    = STATE_WIDTH'(5),
    S_EXECUTE  = STATE_WIDTH'(6),
    S_ALUWB    = STATE_WIDTH'(7),
    S_BRANCH   = STATE_WIDTH'(8),
    S_ADDIEXEC = STATE_WIDTH'(9),
    S_ADDIWB   = STATE_WIDTH'(10),
    S_JUMP     = STATE_WIDTH'(11)
  } state_t;

  localparam logic [OpCode_WIDTH-1:0] OP_LW   = OpCode_WIDTH'(6'b100011);
  localparam logic [OpCode_WIDTH-1:0] OP_SW   = OpCode_WIDTH'(6'b101011);
  localparam logic [OpCode_WIDTH-1:0] OP_RTYP = OpCode_WIDTH'(6'b000000);
  localparam logic [OpCode_WIDTH-1:0] OP_BEQ  = OpCode_WIDTH'(6'b000100);
  localparam logic [OpCode_WIDTH-1:0] OP_ADDI = OpCode_WIDTH'(6'b001000);
  localparam logic [OpCode_WIDTH-1:0] OP_J    = OpCode_WIDTH'(6'b000010);

  localparam logic [Funct_Width-1:0] FN_ADD = Funct_Width'(6'b100000);
  localparam logic [Funct_Width-1:0] FN_SUB = Funct_Width'(6'b100010);
  localparam logic [Funct_Width-1:0] FN_SLT = Funct_Width'(6'b101010);
  localparam logic [Funct_Width-1:0] FN_MUL = Funct_Width'(6'b011100);

  localparam logic [ALUControl_WIDTH-1:0] ALU_ADD = ALUControl_WIDTH'(3'b010);
  localparam logic [ALUControl_WIDTH-1:0] ALU_SUB = ALUControl_WIDTH'(3'b100);
  localparam logic [ALUControl_WIDTH-1:0] ALU_SLT = ALUControl_WIDTH'(3'b110);
  localparam logic [ALUControl_WIDTH-1:0] ALU_MUL = ALUControl_WIDTH'(3'b101);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_branch;
  logic       w_pcwrite;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state and per-state strobe decode
  always_comb begin
    w_next    = r_state;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    w_aluop   = 2'b00;
    w_branch  = 1'b0;
    w_pcwrite = 1'b0;

    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        // IR and PC update only on the cycle the fetch data actually returns
        IRWrite   = Mem_Ready;
        w_pcwrite = Mem_Ready;
        if (Mem_Ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (Mem_Ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (Mem_Ready) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_aluop = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluop  = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      // Unused codes recover to FETCH with every strobe left at its default
      default: w_next = S_FETCH;
    endcase
  end

  // ALU operation decode from ALUOp and Funct
  always_comb begin
    ALUControl = ALU_ADD;
    case (w_aluop)
      2'b01: ALUControl = ALU_SUB;
      2'b10: begin
        case (Funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_SLT:  ALUControl = ALU_SLT;
          FN_MUL:  ALUControl = ALU_MUL;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  assign PCEn  = w_pcwrite | (w_branch & Zero_flag);
  assign State = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed self-checking bench for multicycle_control_fsm. Inputs change and
//   outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero_flag;
  logic       Mem_Ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control_fsm dut (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct),
    .Zero_flag(Zero_flag), .Mem_Ready(Mem_Ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .PCEn(PCEn), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Advance one cycle and check the state code
  task automatic step(input string tag, input logic [3:0] exp_state);
    tick();
    chk(tag, 32'(State), 32'(exp_state));
  endtask

  initial begin
    RST = 1'b1; OpCode = 6'b000000; Funct = 6'b100000;
    Zero_flag = 1'b0; Mem_Ready = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // T1 reset state: FETCH decode
    chk("rst_state",   32'(State), 32'd0);
    chk("rst_alusrcb", 32'(ALUSrcB), 32'd1);
    chk("rst_irwrite", 32'(IRWrite), 32'd1);
    chk("rst_pcen",    32'(PCEn), 32'd1);
    chk("rst_memwr",   32'(MemWrite), 32'd0);
    chk("rst_regwr",   32'(RegWrite), 32'd0);
    chk("rst_aluctl",  32'(ALUControl), 32'b010);
    chk("rst_iord",    32'(IorD), 32'd0);

    // FETCH stall on slow memory
    Mem_Ready = 1'b0;
    #1;
    chk("fstall_irwrite", 32'(IRWrite), 32'd0);
    chk("fstall_pcen",    32'(PCEn), 32'd0);
    step("fstall_hold", 4'd0);
    Mem_Ready = 1'b1;

    // T2 lw: 0,1,2,3,4,0
    OpCode = 6'b100011;
    step("lw_dec", 4'd1);
    chk("lw_dec_alusrcb", 32'(ALUSrcB), 32'd3);
    chk("lw_dec_irwrite", 32'(IRWrite), 32'd0);
    step("lw_adr", 4'd2);
    chk("lw_adr_srca", 32'(ALUSrcA), 32'd1);
    chk("lw_adr_srcb", 32'(ALUSrcB), 32'd2);
    step("lw_rd", 4'd3);
    chk("lw_rd_iord",  32'(IorD), 32'd1);
    chk("lw_rd_regwr", 32'(RegWrite), 32'd0);
    step("lw_wb", 4'd4);
    chk("lw_wb_regwr", 32'(RegWrite), 32'd1);
    chk("lw_wb_m2r",   32'(MemtoReg), 32'd1);
    chk("lw_wb_iord",  32'(IorD), 32'd0);
    step("lw_done", 4'd0);

    // lw with a one-cycle stall in MEMRD
    step("lw2_dec", 4'd1);
    step("lw2_adr", 4'd2);
    step("lw2_rd", 4'd3);
    Mem_Ready = 1'b0;
    step("lw2_rd_hold", 4'd3);
    chk("lw2_rd_hold_iord", 32'(IorD), 32'd1);
    Mem_Ready = 1'b1;
    step("lw2_wb", 4'd4);
    step("lw2_done", 4'd0);

    // T3 R-type slt: 0,1,6,7,0
    OpCode = 6'b000000; Funct = 6'b101010;
    step("r_dec", 4'd1);
    step("r_exe", 4'd6);
    chk("r_exe_slt",  32'(ALUControl), 32'b110);
    chk("r_exe_srca", 32'(ALUSrcA), 32'd1);
    chk("r_exe_srcb", 32'(ALUSrcB), 32'd0);
    Funct = 6'b100010; #1; chk("r_exe_sub", 32'(ALUControl), 32'b100);
    Funct = 6'b011100; #1; chk("r_exe_mul", 32'(ALUControl), 32'b101);
    Funct = 6'b100000; #1; chk("r_exe_add", 32'(ALUControl), 32'b010);
    Funct = 6'b111111; #1; chk("r_exe_oth", 32'(ALUControl), 32'b010);
    Funct = 6'b101010;
    step("r_wb", 4'd7);
    chk("r_wb_regdst", 32'(RegDst), 32'd1);
    chk("r_wb_regwr",  32'(RegWrite), 32'd1);
    step("r_done", 4'd0);

    // T4 beq taken, then not taken
    OpCode = 6'b000100; Zero_flag = 1'b1;
    step("beq1_dec", 4'd1);
    chk("beq1_dec_pcen", 32'(PCEn), 32'd0);
    step("beq1_br", 4'd8);
    chk("beq1_pcen",   32'(PCEn), 32'd1);
    chk("beq1_pcsrc",  32'(PCSrc), 32'd1);
    chk("beq1_aluctl", 32'(ALUControl), 32'b100);
    step("beq1_done", 4'd0);
    Zero_flag = 1'b0;
    step("beq0_dec", 4'd1);
    step("beq0_br", 4'd8);
    chk("beq0_pcen",   32'(PCEn), 32'd0);
    chk("beq0_pcsrc",  32'(PCSrc), 32'd1);
    chk("beq0_aluctl", 32'(ALUControl), 32'b100);
    step("beq0_done", 4'd0);

    // j: 0,1,11,0
    OpCode = 6'b000010;
    step("j_dec", 4'd1);
    step("j_jmp", 4'd11);
    chk("j_pcsrc", 32'(PCSrc), 32'd2);
    chk("j_pcen",  32'(PCEn), 32'd1);
    step("j_done", 4'd0);

    // addi: 0,1,9,10,0
    OpCode = 6'b001000;
    step("addi_dec", 4'd1);
    step("addi_exe", 4'd9);
    chk("addi_exe_srcb", 32'(ALUSrcB), 32'd2);
    chk("addi_exe_aluctl", 32'(ALUControl), 32'b010);
    step("addi_wb", 4'd10);
    chk("addi_wb_regwr",  32'(RegWrite), 32'd1);
    chk("addi_wb_regdst", 32'(RegDst), 32'd0);
    step("addi_done", 4'd0);

    // T5 sw with three stall cycles in MEMWR
    OpCode = 6'b101011;
    step("sw_dec", 4'd1);
    step("sw_adr", 4'd2);
    step("sw_wr", 4'd5);
    Mem_Ready = 1'b0;
    chk("sw_wr_memwr", 32'(MemWrite), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step("sw_wr_hold", 4'd5);
      chk("sw_wr_hold_memwr", 32'(MemWrite), 32'd1);
      if (k == 2) Mem_Ready = 1'b1;
    end
    step("sw_done", 4'd0);

    // T6 unknown opcode acts as NOP
    OpCode = 6'b111111;
    step("nop_dec", 4'd1);
    chk("nop_dec_regwr", 32'(RegWrite), 32'd0);
    chk("nop_dec_memwr", 32'(MemWrite), 32'd0);
    step("nop_done", 4'd0);

    // Reset during a stalled MEMWR
    OpCode = 6'b101011;
    step("swr_dec", 4'd1);
    step("swr_adr", 4'd2);
    step("swr_wr", 4'd5);
    Mem_Ready = 1'b0;
    RST = 1'b1;
    step("swr_rst_state", 4'd0);
    chk("swr_rst_memwr", 32'(MemWrite), 32'd0);
    RST = 1'b0;
    Mem_Ready = 1'b1;
    step("swr_after", 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
